// File: rtl/sys_bus_pkg.sv
// Shared definitions for the system-bus initiator: FSM states, response
// status codes and bus widths.
package sys_bus_pkg;

  localparam int SYS_AW = 32;
  localparam int SYS_DW = 32;
  localparam int SYS_SW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] STS_OK  = 2'b00;
  localparam logic [1:0] STS_ERR = 2'b01;
  localparam logic [1:0] STS_TMO = 2'b10;

endpackage

// File: rtl/sys_bus_master.sv
// Single-outstanding system-bus initiator: command stream in, one bus strobe out,
// response stream back. Define SYS_BUS_MASTER_TIMEOUT_EN to add the ack timeout.
module sys_bus_master
  import sys_bus_pkg::*;
#(
  parameter int unsigned       TMO_CYC   = 255,
  parameter logic [SYS_AW-1:0] ADDR_MASK = 32'hFFFF_FFFF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [SYS_AW-1:0] cmd_addr_i,
  input  logic [SYS_DW-1:0] cmd_wdata_i,
  input  logic [SYS_SW-1:0] cmd_sel_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [SYS_DW-1:0] rsp_rdata_o,
  output logic [1:0]        rsp_status_o,
  output logic              busy_o,
  output logic [SYS_AW-1:0] sys_addr_o,
  output logic [SYS_DW-1:0] sys_wdata_o,
  output logic [SYS_SW-1:0] sys_sel_o,
  output logic              sys_wen_o,
  output logic              sys_ren_o,
  input  logic [SYS_DW-1:0] sys_rdata_i,
  input  logic              sys_err_i,
  input  logic              sys_ack_i
);

  state_t            state_q, state_d;
  logic              is_write_q, is_write_d;
  logic              cmd_ready_d, rsp_valid_d, busy_d, sys_wen_d, sys_ren_d;
  logic [SYS_DW-1:0] rsp_rdata_d, sys_wdata_d;
  logic [1:0]        rsp_status_d;
  logic [SYS_AW-1:0] sys_addr_d;
  logic [SYS_SW-1:0] sys_sel_d;

`ifdef SYS_BUS_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LIM = 16'(TMO_CYC);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // NOTE: every next-value signal gets its hold value first so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    is_write_d   = is_write_q;
    cmd_ready_d  = cmd_ready_o;
    rsp_valid_d  = rsp_valid_o;
    rsp_rdata_d  = rsp_rdata_o;
    rsp_status_d = rsp_status_o;
    sys_addr_d   = sys_addr_o;
    sys_wdata_d  = sys_wdata_o;
    sys_sel_d    = sys_sel_o;
    sys_wen_d    = 1'b0;
    sys_ren_d    = 1'b0;
`ifdef SYS_BUS_MASTER_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d     = ACCESS;
          is_write_d  = cmd_we_i;
          cmd_ready_d = 1'b0;
          sys_addr_d  = cmd_addr_i & ADDR_MASK;
          sys_wdata_d = cmd_wdata_i;
          sys_sel_d   = cmd_sel_i;
          sys_wen_d   = cmd_we_i;
          sys_ren_d   = ~cmd_we_i;
`ifdef SYS_BUS_MASTER_TIMEOUT_EN
          tmo_cnt_d   = '0;
`endif
        end
      end

      // ack/err are looked at in the strobe cycle too, so a responder that
      // answers combinationally completes in a single ACCESS cycle.
      ACCESS: begin
        if (sys_err_i) begin
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          rsp_rdata_d  = '0;
          rsp_status_d = STS_ERR;
        end else if (sys_ack_i) begin
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          rsp_rdata_d  = is_write_q ? '0 : sys_rdata_i;
          rsp_status_d = STS_OK;
        end
`ifdef SYS_BUS_MASTER_TIMEOUT_EN
        else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
          if (tmo_cnt_d == TMO_LIM) begin
            state_d      = RESP;
            rsp_valid_d  = 1'b1;
            rsp_rdata_d  = '0;
            rsp_status_d = STS_TMO;
          end
        end
`endif
      end

      RESP: begin
        if (rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      is_write_q   <= 1'b0;
      cmd_ready_o  <= 1'b1;
      rsp_valid_o  <= 1'b0;
      rsp_rdata_o  <= '0;
      rsp_status_o <= STS_OK;
      busy_o       <= 1'b0;
      sys_addr_o   <= '0;
      sys_wdata_o  <= '0;
      sys_sel_o    <= '0;
      sys_wen_o    <= 1'b0;
      sys_ren_o    <= 1'b0;
`ifdef SYS_BUS_MASTER_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      is_write_q   <= is_write_d;
      cmd_ready_o  <= cmd_ready_d;
      rsp_valid_o  <= rsp_valid_d;
      rsp_rdata_o  <= rsp_rdata_d;
      rsp_status_o <= rsp_status_d;
      busy_o       <= busy_d;
      sys_addr_o   <= sys_addr_d;
      sys_wdata_o  <= sys_wdata_d;
      sys_sel_o    <= sys_sel_d;
      sys_wen_o    <= sys_wen_d;
      sys_ren_o    <= sys_ren_d;
`ifdef SYS_BUS_MASTER_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_sys_bus_master.sv
// Randomized bench for sys_bus_master: a latency-programmable memory responder
// plus a transaction-level model predicting status, data and response latency.
module tb_sys_bus_master;
  import sys_bus_pkg::*;

  localparam int TMO = 16;
`ifdef SYS_BUS_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic        busy;
  logic [31:0] sys_addr, sys_wdata, sys_rdata;
  logic [3:0]  sys_sel;
  logic        sys_wen, sys_ren, sys_err, sys_ack;

  always #5 clk = ~clk;

  sys_bus_master #(.TMO_CYC(TMO), .ADDR_MASK(32'hFFFF_FFFF)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_status_o(rsp_status), .busy_o(busy),
    .sys_addr_o(sys_addr), .sys_wdata_o(sys_wdata), .sys_sel_o(sys_sel),
    .sys_wen_o(sys_wen), .sys_ren_o(sys_ren), .sys_rdata_i(sys_rdata),
    .sys_err_i(sys_err), .sys_ack_i(sys_ack)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Responder: answers each strobe r_lat cycles later (0 = same cycle).
  logic [31:0] resp_mem [64];
  logic [31:0] ref_mem  [64];
  int          r_lat = 1;
  bit          r_err = 1'b0;
  int          pend = -1;
  bit          pend_we, pend_err;
  logic [5:0]  pend_idx;
  int          spur_cnt = 0;
  int          spur_done = 0;

  initial begin
    bit rst_at_edge;
    sys_ack = 1'b0; sys_err = 1'b0; sys_rdata = '0;
    forever begin
      @(posedge clk);
      rst_at_edge = rst;
      #1;
      sys_ack = 1'b0; sys_err = 1'b0; sys_rdata = $urandom;
      if (rst_at_edge || rst) begin
        pend = -1;
      end else if (sys_wen || sys_ren) begin
        pend     = r_lat;
        pend_we  = sys_wen;
        pend_err = r_err;
        pend_idx = sys_addr[7:2];
        if (sys_wen && !r_err)
          for (int b = 0; b < 4; b++)
            if (sys_sel[b]) resp_mem[sys_addr[7:2]][8*b +: 8] = sys_wdata[8*b +: 8];
      end
      if (pend == 0) begin
        sys_ack = 1'b1;
        sys_err = pend_err;
        if (!pend_we && !pend_err) sys_rdata = resp_mem[pend_idx];
      end
      if (pend >= 0) pend--;
      if (spur_cnt != spur_done) begin
        sys_ack = 1'b1; sys_err = 1'($urandom); spur_done = spur_cnt;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // One complete command/response; early=1 presents a read of 0x0 on the
  // command port while the response is pending, for the caller to reissue.
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel, input int lat, input bit err,
                         input int hold, input bit early);
    logic [1:0]  exp_sts;
    logic [31:0] exp_rdata, hold_rdata;
    logic [1:0]  hold_sts;
    int          exp_t, t, idx;
    bit          ok;
    bit          timed_out;

    idx       = int'(addr[7:2]);
    timed_out = TMO_EN && (lat + 1 > TMO);
    exp_sts   = timed_out ? STS_TMO : (err ? STS_ERR : STS_OK);
    exp_rdata = (exp_sts == STS_OK && !we) ? ref_mem[idx] : 32'h0;
    exp_t     = timed_out ? TMO + 1 : lat + 2;
    if (we && !err)
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];

    r_lat = lat; r_err = err;
    check("accept_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_sel = sel;
    tick();
    cmd_valid = 1'b0; cmd_we = $urandom; cmd_addr = $urandom; cmd_wdata = $urandom;
    check("strobe_wen", sys_wen, we);
    check("strobe_ren", sys_ren, !we);
    check("strobe_addr", sys_addr, addr);
    check("strobe_wdata", sys_wdata, wdata);
    check("strobe_sel", sys_sel, sel);
    check("strobe_busy", {cmd_ready, busy}, 2'b01);

    t = 1; ok = 1'b1;
    while (!rsp_valid && t < 200) begin
      tick();
      t++;
      if (!rsp_valid)
        ok &= (sys_wen == 0) && (sys_ren == 0) && (sys_addr == addr) &&
              (sys_wdata == wdata) && (sys_sel == sel) && busy && !cmd_ready;
    end
    check("access_stable", ok, 1);
    check("rsp_latency", t, exp_t);
    check("rsp_status", rsp_status, exp_sts);
    check("rsp_rdata", rsp_rdata, exp_rdata);

    hold_rdata = rsp_rdata; hold_sts = rsp_status; ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (early) begin cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_sel = 4'hF; end
      tick();
      ok &= rsp_valid && (rsp_rdata == hold_rdata) && (rsp_status == hold_sts) &&
            !cmd_ready && busy && !sys_ren && !sys_wen;
    end
    if (hold > 0) check("rsp_hold_stable", ok, 1);

    if (early) begin cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_sel = 4'hF; end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_idle("post_hs");
    check("post_hs_no_strobe", {sys_wen, sys_ren}, 2'b00);

    if (timed_out) begin
      ok = 1'b1; t = 0;
      while (pend >= 0 && t < 50) begin
        tick(); t++;
        ok &= cmd_ready && !rsp_valid && !busy && !sys_ren && !sys_wen;
      end
      tick();
      ok &= cmd_ready && !rsp_valid && !busy;
      check("late_ack_ignored", ok, 1);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_idle(tag);
    check({tag, "_status"}, rsp_status, 0);
    check({tag, "_rdata"}, rsp_rdata, 0);
    check({tag, "_bus"}, {sys_wen, sys_ren, sys_sel}, 0);
    check({tag, "_addr"}, sys_addr, 0);
    check({tag, "_wdata"}, sys_wdata, 0);
  endtask

  initial begin
    logic [31:0] a, d;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_sel = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      d = $urandom; resp_mem[i] = d; ref_mem[i] = d;
    end
    resp_mem[0] = 32'h1; ref_mem[0] = 32'h1;
    #2;
    check_reset_values("reset");
    tick(); tick();
    rst = 1'b0;
    tick();

    run_txn(1'b0, 32'h0, 32'h0, 4'hF, 1, 1'b0, 0, 1'b0);
    run_txn(1'b1, 32'h30, 32'hA5, 4'hF, 1, 1'b0, 0, 1'b0);
    run_txn(1'b0, 32'h30, 32'h0, 4'hF, 1, 1'b0, 0, 1'b0);
    run_txn(1'b0, 32'h40, 32'h0, 4'hF, 1, 1'b1, 0, 1'b0);
    run_txn(1'b0, 32'h44, 32'h0, 4'hF, 0, 1'b0, 0, 1'b0);
    run_txn(1'b1, 32'h48, 32'hDEADBEEF, 4'b0101, 2, 1'b0, 0, 1'b0);
    run_txn(1'b0, 32'h48, 32'h0, 4'hF, 3, 1'b0, 0, 1'b0);
    if (TMO_EN) begin
      run_txn(1'b0, 32'h50, 32'h0, 4'hF, TMO + 3, 1'b0, 0, 1'b0);
      run_txn(1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b0, 0, 1'b0);
      run_txn(1'b0, 32'h54, 32'h0, 4'hF, TMO - 1, 1'b0, 0, 1'b0);
    end

    run_txn(1'b0, 32'h30, 32'h0, 4'hF, 1, 1'b0, 10, 1'b1);
    run_txn(1'b0, 32'h0, 32'h0, 4'hF, 1, 1'b0, 0, 1'b0);

    spur_cnt++;
    tick(); tick();
    check_idle("spurious");

    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h8; cmd_sel = 4'hF; r_lat = 3; r_err = 1'b0;
    tick();
    cmd_valid = 1'b0;
    check("rst_pre_strobe", sys_ren, 1);
    tick();
    rst = 1'b1;
    #1;
    check_reset_values("mid_rst");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_idle("after_rst");
    run_txn(1'b0, 32'h4, 32'h0, 4'hF, 1, 1'b0, 0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      int lat;
      lat = $urandom_range(0, 4);
      if (TMO_EN && ($urandom_range(0, 7) == 0)) lat = TMO - 2 + $urandom_range(0, 4);
      a = $urandom;
      run_txn(1'($urandom), a, $urandom, 4'($urandom), lat,
              ($urandom_range(0, 9) == 0), $urandom_range(0, 3), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
